// File: rtl/iram_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// iram_fetch_ctrl
//
// Instruction-fetch and halt sequencer for the lab5 16-bit processor.
// Owns the program counter and drives the byte address into the 128x16
// instruction RAM, which reads combinationally (INSTR = mem[ADDR[7:1]]).
// It marks each returned word as valid for the datapath and decodes the
// HALT word itself. After a HALT, fetch stays frozen until the operator
// raises RESUME. It also supports single-step, datapath stall and
// taken-branch redirect.
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous active-high reset (also the RAM load window)
//   INSTR      in   [15:0] word read from the RAM at ADDR, same cycle
//   STALL      in   datapath busy: hold PC and state
//   BR_TAKEN   in   current instruction redirects fetch
//   BR_TARGET  in   [7:0] redirect byte address (bit 0 ignored)
//   STEP_MODE  in   halt after every executed instruction
//   RESUME     in   asynchronous operator level, acts on its rising edge
//   ADDR       out  [7:0] byte address to the RAM (= PC, bit 0 always 0)
//   IR_VALID   out  INSTR is executed by the datapath this cycle
//   HALTED     out  fetch frozen, waiting for RESUME
//   HALT_CNT   out  [CNT_W-1:0] saturating count of HALT entries
// ---------------------------------------------------------------------------
module iram_fetch_ctrl #(
   parameter logic [7:0]  RESET_PC  = 8'h00,
   parameter logic [15:0] HALT_WORD = 16'h0001,
   parameter int          CNT_W     = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [15:0]      INSTR,
   input  logic             STALL,
   input  logic             BR_TAKEN,
   input  logic [7:0]       BR_TARGET,
   input  logic             STEP_MODE,
   input  logic             RESUME,
   output logic [7:0]       ADDR,
   output logic             IR_VALID,
   output logic             HALTED,
   output logic [CNT_W-1:0] HALT_CNT
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t           state_reg;
   // The PC is kept as a word address. Byte-address arithmetic modulo 256
   // with bit 0 fixed at 0 is the same thing as word arithmetic modulo 128.
   logic [6:0]       pc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             halted_reg;

   // RESUME is asynchronous: it passes through two synchronizer flops, and
   // the previous synchronized value is then kept for edge detection.
   logic             sync1_reg;
   logic             sync2_reg;
   logic             prev_reg;

   logic             resume_edge;
   logic             is_halt_word;
   logic             unused_target_lsb;

   assign is_halt_word      = (INSTR == HALT_WORD);
   assign resume_edge       = sync2_reg & ~prev_reg;
   assign unused_target_lsb = BR_TARGET[0];

   assign ADDR     = {pc_reg, 1'b0};
   // Combinational so that RUN issues one instruction per cycle with no
   // fetch bubble. The HALT word itself is never handed to the datapath.
   assign IR_VALID = (state_reg == S_RUN) && !is_halt_word;
   assign HALTED   = halted_reg;
   assign HALT_CNT = cnt_reg;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg  <= S_BOOT;
         pc_reg     <= RESET_PC[7:1];
         cnt_reg    <= '0;
         halted_reg <= 1'b0;
         sync1_reg  <= 1'b0;
         sync2_reg  <= 1'b0;
         prev_reg   <= 1'b0;
      end else begin
         sync1_reg <= RESUME;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;

         case (state_reg)
            // The RAM is loaded during RESET, so one settling cycle passes
            // before the first instruction is trusted.
            S_BOOT: begin
               state_reg <= S_RUN;
            end

            S_RUN: begin
               if (!STALL) begin
                  if (is_halt_word) begin
                     // The HALT word wins over any branch request. Execution
                     // resumes at the word after it.
                     pc_reg     <= pc_reg + 7'd1;
                     state_reg  <= S_HALT;
                     halted_reg <= 1'b1;
                     if (cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                     end
                  end else begin
                     if (BR_TAKEN) begin
                        pc_reg <= BR_TARGET[7:1];
                     end else begin
                        pc_reg <= pc_reg + 7'd1;
                     end
                     // Single-step halts after the PC update and does not
                     // count as a HALT entry.
                     if (STEP_MODE) begin
                        state_reg  <= S_HALT;
                        halted_reg <= 1'b1;
                     end
                  end
               end
            end

            // Resume edges seen in any other state are dropped. The edge
            // register keeps advancing, so such an edge is consumed.
            S_HALT: begin
               if (resume_edge) begin
                  state_reg  <= S_RUN;
                  halted_reg <= 1'b0;
               end
            end

            default: begin
               state_reg  <= S_BOOT;
               halted_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iram_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for iram_fetch_ctrl.
//
// A behavioural model, driven by the same stimulus as the DUT, predicts
// ADDR / IR_VALID / HALTED / HALT_CNT for every cycle. Each prediction is
// pushed into a queue. A monitor on the falling edge pops the queue and
// compares the prediction with the DUT outputs. The instruction RAM is a
// bench array read combinationally at ADDR.
// ---------------------------------------------------------------------------
module tb_iram_fetch_ctrl;

   localparam logic [15:0] HALT_W = 16'h0001;
   localparam int M_BOOT = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        STALL = 1'b0;
   logic        BR_TAKEN = 1'b0;
   logic [7:0]  BR_TARGET = 8'h00;
   logic        STEP_MODE = 1'b0;
   logic        RESUME = 1'b0;
   logic [15:0] INSTR;
   logic [7:0]  ADDR;
   logic        IR_VALID;
   logic        HALTED;
   logic [7:0]  HALT_CNT;

   logic [15:0] mem [128];

   assign INSTR = mem[ADDR[7:1]];

   always #5 CLK = ~CLK;

   iram_fetch_ctrl #(
      .RESET_PC  (8'h00),
      .HALT_WORD (16'h0001),
      .CNT_W     (8)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .INSTR     (INSTR),
      .STALL     (STALL),
      .BR_TAKEN  (BR_TAKEN),
      .BR_TARGET (BR_TARGET),
      .STEP_MODE (STEP_MODE),
      .RESUME    (RESUME),
      .ADDR      (ADDR),
      .IR_VALID  (IR_VALID),
      .HALTED    (HALTED),
      .HALT_CNT  (HALT_CNT)
   );

   typedef struct {
      int addr;
      int irv;
      int halted;
      int cnt;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state: mode, byte PC, halt count, cycle number, the
   // cycle of the last RESUME rise seen at the pins, and the previous pin
   // value.
   int   m_mode = M_BOOT;
   int   m_pc = 0;
   int   m_cnt = 0;
   int   m_cyc = 0;
   int   m_rise = -100;
   int   m_last_pin = 0;
   bit   warm = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int cyc);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: one prediction per cycle, compared mid-cycle.
   always @(negedge CLK) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         chk("ADDR",     {24'd0, ADDR},     mon_e.addr,   mon_e.cyc);
         chk("IR_VALID", {31'd0, IR_VALID}, mon_e.irv,    mon_e.cyc);
         chk("HALTED",   {31'd0, HALTED},   mon_e.halted, mon_e.cyc);
         chk("HALT_CNT", {24'd0, HALT_CNT}, mon_e.cnt,    mon_e.cyc);
      end
   end

   function automatic logic [15:0] rnd_word(input int halt_pct);
      logic [15:0] w;
      if (int'($urandom_range(0, 99)) < halt_pct) begin
         w = HALT_W;
      end else begin
         w = 16'($urandom);
         if (w == HALT_W) w = 16'h8001;
      end
      return w;
   endfunction

   task automatic load_mem(input int halt_pct);
      for (int i = 0; i < 128; i++) mem[i] = rnd_word(halt_pct);
   endtask

   // One clock cycle: apply the inputs, predict the outputs for this cycle,
   // then advance the model across the rising edge.
   task automatic step(input bit rst, input bit stl, input bit br, input logic [7:0] tgt,
                       input bit stp, input bit res);
      exp_t e;
      bit   edge_seen;
      RESET     = rst;
      STALL     = stl;
      BR_TAKEN  = br;
      BR_TARGET = tgt;
      STEP_MODE = stp;
      RESUME    = res;
      if (warm) begin
         e.addr   = m_pc;
         e.irv    = (m_mode == M_RUN && mem[m_pc >> 1] != HALT_W) ? 1 : 0;
         e.halted = (m_mode == M_HALT) ? 1 : 0;
         e.cnt    = m_cnt;
         e.cyc    = m_cyc;
         sb.push_back(e);
      end
      @(posedge CLK);
      #1;
      // A rise at the pins is seen by the controller two cycles later, and
      // acts on the edge that ends that cycle.
      edge_seen = (m_rise == m_cyc - 2);
      if (!rst && res && m_last_pin == 0) m_rise = m_cyc;
      m_last_pin = (rst || !res) ? 0 : 1;
      if (rst) begin
         m_mode = M_BOOT;
         m_pc   = 0;
         m_cnt  = 0;
         m_rise = -100;
         warm   = 1'b1;
      end else begin
         case (m_mode)
            M_BOOT: m_mode = M_RUN;
            M_RUN: begin
               if (!stl) begin
                  if (mem[m_pc >> 1] == HALT_W) begin
                     m_pc   = (m_pc + 2) % 256;
                     m_mode = M_HALT;
                     if (m_cnt < 255) m_cnt = m_cnt + 1;
                  end else begin
                     m_pc = br ? (int'(tgt) & 254) : (m_pc + 2) % 256;
                     if (stp) m_mode = M_HALT;
                  end
               end
            end
            default: if (edge_seen) m_mode = M_RUN;
         endcase
      end
      m_cyc++;
   endtask

   task automatic idle(input int n, input bit res);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, res);
   endtask

   task automatic wait_mode(input int mode, input int maxc, input bit stp);
      for (int i = 0; i < maxc && m_mode != mode; i++) step(0, 0, 0, 8'h00, stp, 0);
   endtask

   initial begin
      bit res_v;
      bit stp_en;

      // Program A: HALT words at byte 0x08 and 0x18.
      load_mem(0);
      mem[4]  = HALT_W;
      mem[12] = HALT_W;
      step(1, 0, 0, 8'h00, 0, 0);
      step(1, 0, 0, 8'h00, 0, 0);
      wait_mode(M_HALT, 20, 0);
      idle(2, 0);
      idle(20, 1);                 // long RESUME: one resume, then halt at 0x18
      idle(4, 0);
      $display("[TB] phase halt/resume done at cycle %0d, halt_cnt model %0d", m_cyc, m_cnt);

      // Branch, stall and PC wrap.
      load_mem(0);
      step(1, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 10 && !(m_mode == M_RUN && m_pc == 4); i++) idle(1, 0);
      step(0, 0, 1, 8'h21, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 8'($urandom), 1, 0);
      step(0, 0, 1, 8'hFF, 0, 0);
      idle(3, 0);
      $display("[TB] phase branch/stall/wrap done at cycle %0d", m_cyc);

      // Single-step: one instruction per RESUME edge.
      step(0, 0, 0, 8'h00, 1, 0);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 8'h00, 1, 1);
         wait_mode(M_RUN, 6, 1);
         wait_mode(M_HALT, 6, 1);
      end
      $display("[TB] phase single-step done at cycle %0d", m_cyc);

      // Saturation: every word is HALT.
      for (int i = 0; i < 128; i++) mem[i] = HALT_W;
      step(1, 0, 0, 8'h00, 0, 0);
      wait_mode(M_HALT, 6, 0);
      for (int k = 0; k < 300; k++) begin
         step(0, 0, 0, 8'h00, 0, 1);
         wait_mode(M_RUN, 6, 0);
         wait_mode(M_HALT, 6, 0);
      end
      idle(2, 0);
      step(1, 0, 0, 8'h00, 0, 0);   // reset while halted
      idle(3, 0);
      $display("[TB] phase saturation/reset done at cycle %0d", m_cyc);

      // Randomised segments.
      for (int s = 0; s < 8; s++) begin
         load_mem(12);
         stp_en = ($urandom_range(0, 2) == 0);
         res_v  = 1'b0;
         step(1, 0, 0, 8'h00, 0, 0);
         for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) res_v = ~res_v;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0,
                 8'($urandom),
                 stp_en && ($urandom_range(0, 2) == 0),
                 res_v);
         end
         $display("[TB] random segment %0d done at cycle %0d, halt_cnt model %0d", s, m_cyc, m_cnt);
      end

      idle(1, 0);
      chk("scoreboard_drain", sb.size(), 0, m_cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iram_fetch_ctrl.md
# iram_fetch_ctrl

Instruction-fetch and halt sequencer for the lab5 16-bit processor. It owns the program counter, drives the byte address into the 128×16 instruction RAM, and qualifies each returned word for the datapath. It decodes the HALT word itself, freezes fetch until an operator RESUME edge, and supports single-step, datapath stall and taken-branch redirect. It sits between the instruction RAM (combinational read, `Q = mem[ADDR[7:1]]`) and the decode/execute stage.

## Interface
- RESET_PC, 8'h00, byte address loaded into PC on reset; bit 0 must be 0.
- HALT_WORD, 16'h0001, instruction encoding treated as HALT.
- CNT_W, 8, width of the halt counter.

- CLK  in  1  single system clock, rising edge.
- RESET  in  1  synchronous, active-high reset, sampled on the CLK rising edge. Also the instruction RAM's load window.
- INSTR  in  16  word read from instruction RAM at ADDR, same cycle.
- STALL  in  1  datapath busy; holds PC and state.
- BR_TAKEN  in  1  current instruction redirects fetch.
- BR_TARGET  in  8  byte address of the redirect; bit 0 ignored and forced to 0.
- STEP_MODE  in  1  when 1, halt after every executed instruction.
- RESUME  in  1  asynchronous-level operator input; acts on its rising edge.
- ADDR  out  8  byte address to instruction RAM (= PC); bit 0 always 0.
- IR_VALID  out  1  INSTR is a real instruction the datapath executes this cycle.
- HALTED  out  1  fetch frozen, waiting for RESUME.
- HALT_CNT  out  CNT_W  number of HALT entries since reset; saturating.

## Operation
- States: BOOT, RUN, HALTED.
- BOOT
  - Entered on RESET. Lasts exactly one cycle after RESET deasserts, because RAM contents are written during RESET. Then moves to RUN.
  - IR_VALID = 0.
- RUN
  - IR_VALID = 1 unless INSTR == HALT_WORD.
  - With STALL = 0, each cycle:
    - INSTR == HALT_WORD → PC ← PC+2, go to HALTED, HALT_CNT increments (saturates at all-ones). BR_TAKEN is ignored in this case.
    - Otherwise, BR_TAKEN = 1 → PC ← {BR_TARGET[7:1],0}; else PC ← PC+2. Then, if STEP_MODE = 1, go to HALTED without incrementing HALT_CNT.
  - With STALL = 1: PC and state are held, and IR_VALID keeps its combinational value. BR_TAKEN, HALT detection and STEP_MODE are not acted on.
- HALTED
  - HALTED = 1, IR_VALID = 0, PC frozen. STALL and BR_TAKEN are ignored.
  - RUN is re-entered on the cycle after a RESUME rising edge is detected while in HALTED.
- RESUME edge detection
  - Two-flop synchronizer, then an edge register: edge = sync & ~prev.
  - An edge that occurs while not in HALTED is discarded, including the cycle in which the transition into HALTED happens.
- PC arithmetic
  - 8-bit, modulo 256: 8'hFE + 2 = 8'h00.
  - ADDR[0] is tied to 0.
- Reset mid-operation: any state returns to BOOT and PC to RESET_PC on the next edge. HALT_CNT and the synchronizer registers are cleared.

## Timing
- Reset values: ADDR = RESET_PC, IR_VALID = 0, HALTED = 0, HALT_CNT = 0, state = BOOT.
- ADDR is registered. INSTR and IR_VALID are combinational in the same cycle: one instruction per cycle with zero fetch bubble in RUN.
- A branch takes effect on ADDR at the next edge, so there is no delay slot.
- The HALT word is visible on ADDR for one cycle with IR_VALID = 0. HALTED asserts at the next edge.
- RESUME latency, from the RESUME rising edge at the pins to HALTED = 0: 3 CLK edges (2 synchronizer flops plus the edge/state update). The first instruction after resume is issued in that cycle.
- Priority order: RESET > STALL > HALT detect > BR_TAKEN > PC+2; STEP_MODE is evaluated after the PC update.

## Test plan
- Reset, then release with the RAM program loaded:
  - ADDR = 0x00 and IR_VALID = 0 for the BOOT cycle.
  - ADDR then steps 0x00, 0x02, 0x04, 0x06, each with IR_VALID = 1.
  - At ADDR = 0x08 (word 4 = 0x0001): IR_VALID = 0. Next cycle HALTED = 1, ADDR = 0x0A, HALT_CNT = 1.
- From HALTED at 0x0A, pulse RESUME high for 5 cycles:
  - HALTED drops 3 edges after the rise.
  - Execution continues 0x0A through 0x16; the halt at 0x18 gives HALT_CNT = 2.
  - Holding RESUME high produces no second resume.
- BR_TAKEN = 1 with BR_TARGET = 0x21 at ADDR = 0x04 → next ADDR = 0x20. Assert STALL for 3 cycles at 0x20 → ADDR stays at 0x20 and IR_VALID stays 1.
- STEP_MODE = 1 → exactly one IR_VALID cycle per RESUME edge, PC advancing by 2 each time, and HALT_CNT unchanged.
- Force PC to 0xFE via branch with a non-HALT instruction → next ADDR = 0x00.
- Run HALT_WORD 300 times → HALT_CNT saturates at 0xFF. Assert RESET while HALTED → BOOT, ADDR = 0x00, HALT_CNT = 0, HALTED = 0.
